// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: arbiter state type and the select-width rule shared with the channel mux
package cpu_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic int sel_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first requester at or after start (wrapping), optionally skipping one index
module rr_priority_picker
    import cpu_arb_pkg::*;
#(
    parameter int M     = 4,
    parameter int SEL_W = sel_width(M)
) (
    input  logic [M-1:0]     req,
    input  logic [SEL_W-1:0] start,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    localparam logic [SEL_W:0] LP_M = (SEL_W+1)'(M);

    logic [M-1:0]     w_mask;
    logic [M-1:0]     w_rot;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W:0]   w_sum;

    assign w_mask = req & ~(excl_en ? (M'(1) << excl) : '0);
    assign w_rot  = M'({w_mask, w_mask} >> start);

    // find-first on the rotated vector: lowest set bit is the nearest requester after start
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_off = SEL_W'(k);
            end
        end
    end

    assign w_sum  = {1'b0, start} + {1'b0, w_off};
    assign winner = (w_sum >= LP_M) ? SEL_W'(w_sum - LP_M) : w_sum[SEL_W-1:0];

endmodule

// File: rtl/rr_channel_arbiter.sv
// rr_channel_arbiter: round-robin arbiter with hold-time preemption driving a glitch-free mux select/enable
module rr_channel_arbiter
    import cpu_arb_pkg::*;
#(
    parameter  int M        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int SEL_W    = sel_width(M),
    localparam int HC_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req,
    output logic [M-1:0]     grant,
    output logic [SEL_W-1:0] select,
    output logic             enable,
    output logic             busy,
    output logic             preempted
);

    arb_state_t       r_state, w_state;
    logic [SEL_W-1:0] r_ptr, w_ptr;
    logic [SEL_W-1:0] r_sel, w_sel;
    logic [HC_W-1:0]  r_hold, w_hold;
    logic [M-1:0]     r_grant, w_grant;
    logic             r_pre, w_pre;
    logic [SEL_W-1:0] w_nxt;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_win;
    logic             w_found;
    logic             w_own;

    assign w_own   = req[r_sel];
    assign w_nxt   = (r_sel == SEL_W'(M - 1)) ? '0 : r_sel + 1'b1;
    assign w_start = (r_state == IDLE) ? r_ptr : w_nxt;

    // one picker serves both idle arbitration (from ptr) and handover (after owner, owner excluded)
    rr_priority_picker #(.M(M), .SEL_W(SEL_W)) u_pick (
        .req     (req),
        .start   (w_start),
        .excl_en (r_state == GRANT),
        .excl    (r_sel),
        .found   (w_found),
        .winner  (w_win)
    );

    // next-state: grant, release/handover, hold-limit preemption
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_sel   = r_sel;
        w_hold  = r_hold;
        w_pre   = 1'b0;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_state = GRANT;
                w_sel   = w_win;
                w_hold  = '0;
            end
        end else if (!w_own) begin
            w_ptr  = w_nxt;
            w_hold = '0;
            w_state = w_found ? GRANT : IDLE;
            w_sel   = w_found ? w_win : '0;
        end else if (MAX_HOLD > 0 && r_hold == HC_W'(MAX_HOLD - 1)) begin
            w_hold = '0;
            if (w_found) begin
                w_sel = w_win;
                w_ptr = w_nxt;
                w_pre = 1'b1;
            end
        end else begin
            w_hold = (MAX_HOLD == 0) ? '0 : r_hold + 1'b1;
        end
        w_grant = (w_state == GRANT) ? (M'(1) << w_sel) : '0;
    end

    // registered state so grant/select/enable never glitch into the mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_hold  <= '0;
            r_grant <= '0;
            r_pre   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_sel   <= w_sel;
            r_hold  <= w_hold;
            r_grant <= w_grant;
            r_pre   <= w_pre;
        end
    end

    assign grant     = r_grant;
    assign select    = r_sel;
    assign enable    = (r_state == GRANT);
    assign busy      = enable;
    assign preempted = r_pre;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// tb_rr_channel_arbiter: directed and random checks of three arbiter configurations against a behavioural model
module tb_rr_channel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] qa, qb;
    logic [2:0] qc;
    logic [3:0] ga, gb;
    logic [2:0] gc;
    logic [1:0] sa, sb, sc;
    logic       ea, eb, ec, ba, bb, bc, pa, pb, pc;

    int checks = 0;
    int errors = 0;

    int mm[3]   = '{4, 4, 3};
    int mmax[3] = '{4, 0, 2};
    int mo[3];
    int mp[3];
    int mh[3];
    bit mpre[3];
    int ord[5]  = '{0, 1, 2, 3, 0};

    logic [3:0] ra, rb, r;
    logic [2:0] rc;

    rr_channel_arbiter #(.M(4), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .req(qa), .grant(ga), .select(sa),
        .enable(ea), .busy(ba), .preempted(pa)
    );
    rr_channel_arbiter #(.M(4), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .req(qb), .grant(gb), .select(sb),
        .enable(eb), .busy(bb), .preempted(pb)
    );
    rr_channel_arbiter #(.M(3), .MAX_HOLD(2)) u_c (
        .clk(clk), .rst(rst), .req(qc), .grant(gc), .select(sc),
        .enable(ec), .busy(bc), .preempted(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int m, input logic [3:0] rq, input int st, input int ex);
        for (int k = 0; k < m; k++) begin
            int c;
            c = (st + k) % m;
            if (rq[c] && c != ex) return c;
        end
        return -1;
    endfunction

    task automatic mstep(input int i, input logic [3:0] rq);
        int w;
        int nx;
        mpre[i] = 1'b0;
        if (mo[i] < 0) begin
            w = pick(mm[i], rq, mp[i], -1);
            if (w >= 0) begin
                mo[i] = w;
                mh[i] = 0;
            end
        end else begin
            nx = (mo[i] + 1) % mm[i];
            if (!rq[mo[i]]) begin
                mp[i] = nx;
                mo[i] = pick(mm[i], rq, nx, mo[i]);
                mh[i] = 0;
            end else if (mmax[i] > 0 && mh[i] == mmax[i] - 1) begin
                mh[i] = 0;
                w = pick(mm[i], rq, nx, mo[i]);
                if (w >= 0) begin
                    mp[i] = nx;
                    mo[i] = w;
                    mpre[i] = 1'b1;
                end
            end else begin
                mh[i]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mo[i] = -1;
            mp[i] = 0;
            mh[i] = 0;
            mpre[i] = 1'b0;
        end
    endtask

    task automatic chk(input int i, input logic [3:0] g, input logic [1:0] s,
                       input logic e, input logic b, input logic p);
        logic [3:0] eg;
        logic [1:0] es;
        logic       ee;
        eg = (mo[i] >= 0) ? (4'd1 << mo[i]) : 4'd0;
        es = (mo[i] >= 0) ? 2'(mo[i]) : 2'd0;
        ee = (mo[i] >= 0);
        checks++;
        assert (g === eg) else begin errors++; $error("FAIL dut%0d grant got %b exp %b", i, g, eg); end
        checks++;
        assert (s === es) else begin errors++; $error("FAIL dut%0d select got %0d exp %0d", i, s, es); end
        checks++;
        assert (e === ee) else begin errors++; $error("FAIL dut%0d enable got %b exp %b", i, e, ee); end
        checks++;
        assert (b === ee) else begin errors++; $error("FAIL dut%0d busy got %b exp %b", i, b, ee); end
        checks++;
        assert (p === mpre[i]) else begin errors++; $error("FAIL dut%0d preempted got %b exp %b", i, p, mpre[i]); end
    endtask

    task automatic chk_all();
        chk(0, ga, sa, ea, ba, pa);
        chk(1, gb, sb, eb, bb, pb);
        chk(2, {1'b0, gc}, sc, ec, bc, pc);
    endtask

    task automatic expect_v(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
    endtask

    task automatic tick(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        @(negedge clk);
        rst = 1'b0;
        qa = a;
        qb = b;
        qc = c;
        @(posedge clk);
        mstep(0, a);
        mstep(1, b);
        mstep(2, {1'b0, c});
        #1;
        chk_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        qa = '0;
        qb = '0;
        qc = '0;
        #1;
        model_reset();
        chk_all();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    initial begin
        rst = 1'b1;
        qa = '0;
        qb = '0;
        qc = '0;
        model_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b0000, 4'b0000, 3'b000);
            expect_v("idle_enable", ea, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(4'b0100, 4'b0100, 3'b100);
            expect_v("single_sel", sa, 2);
            expect_v("single_grant", ga, 4);
        end
        tick(4'b0000, 4'b0000, 3'b000);
        expect_v("single_drop", ea, 0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            r = 4'hF;
            if (mo[0] >= 0 && mh[0] == 1) r[mo[0]] = 1'b0;
            tick(r, r, r[2:0]);
            if (i % 2 == 0) expect_v("rr_order", sa, ord[i/2]);
            expect_v("rr_no_bubble", ea, 1);
        end
        do_reset();
        for (int i = 0; i < 50; i++) begin
            tick(4'b0011, 4'b0011, 3'b011);
            expect_v("pre_sel", sa, (i / 4) % 2);
            expect_v("pre_pulse", pa, (i % 4 == 0 && i > 0) ? 1 : 0);
            expect_v("nohold_sel", sb, 0);
            expect_v("nohold_pre", pb, 0);
        end
        for (int i = 0; i < 20; i++) begin
            tick(4'b0001, 4'b0001, 3'b001);
            expect_v("alone_sel", sa, 0);
            expect_v("alone_pre", pa, 0);
        end
        do_reset();
        for (int i = 0; i < 3; i++) tick(4'b1000, 4'b1000, 3'b100);
        expect_v("mid_grant", ga, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        expect_v("async_clear", ga, 0);
        @(posedge clk);
        #1;
        chk_all();
        tick(4'b1001, 4'b1001, 3'b001);
        expect_v("restart_ch0", ga, 1);
        ra = '0;
        rb = '0;
        rc = '0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) ra[k] = ~ra[k];
                if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
                if (k < 3 && $urandom_range(0, 3) == 0) rc[k] = ~rc[k];
            end
            if ($urandom_range(0, 63) == 0) do_reset();
            tick(ra, rb, rc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_channel_arbiter.md
Name: rr_channel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the CPU's enabled M-channel multiplexer.
- Takes M request lines and grants exactly one channel at a time.
- Drives the mux select index and enable from registered state, so the mux output is glitch-free.
- A grant is held while the owner keeps its request asserted. A hold-time limit forces fairness.

Parameters:
- M, 4, number of requesting channels. Legal range 1..128.
- MAX_HOLD, 16, maximum consecutive grant cycles before a forced handover. 0 disables preemption.
- SEL_W, derived as ceil(log2 M) with a minimum of 1. Must match the mux select width. Not user-overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  M  per-channel request, level; held high by the requester until done.
- grant  output  M  one-hot grant, registered; all zero when idle.
- select  output  SEL_W  index of granted channel, registered; feeds the mux select.
- enable  output  1  high while any grant is active; feeds the mux enabler.
- busy  output  1  equals enable; provided for status/stall logic.
- preempted  output  1  one-cycle pulse on the cycle a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant=0, select=0, enable=0, busy=0, preempted=0.
  - Outputs are held at these values for as long as rst=1.
- States: IDLE, GRANT.
- Pick function: first channel with req=1, scanning from ptr upward with wrap at M-1 to 0. An optional exclude index is skipped.
- IDLE:
  - If any req is high at a clock edge, pick a winner from ptr. On that edge: owner=winner, state=GRANT, hold_cnt=0.
  - Outputs reflect the new grant from that edge, so there is 1-cycle latency from req to grant.
  - If no req is high, stay in IDLE.
- GRANT, evaluated each edge:
  - Owner's req dropped: pick from owner+1, excluding owner. If a winner exists, hand over on the same edge with no bubble cycle. Otherwise go to IDLE with all outputs 0. In both cases ptr=owner+1 mod M.
  - Owner's req still high, MAX_HOLD>0, hold_cnt==MAX_HOLD-1, and another req is pending: forced handover to pick(owner+1, exclude owner). ptr=owner+1, hold_cnt=0, preempted=1 for one cycle.
  - Owner's req still high, limit reached, nothing else pending: keep the grant, hold_cnt=0, no preempted pulse.
  - Otherwise: hold_cnt+1, grant unchanged.
- hold_cnt width is ceil(log2(MAX_HOLD+1)). It never exceeds MAX_HOLD-1.
- Exactly one grant bit is ever high. grant[select]==1 whenever enable==1.
- M=1: select is tied to 0. Preemption never fires because no other requester exists.
- A new request arriving on the same edge as a handover is eligible under normal pick order.
- Reset asserted mid-grant clears everything immediately. After reset, arbitration restarts from ptr=0.

Decomposition:
- Shared package, cpu_arb_pkg:
  - function sel_width(M), the ceil-log2 rule used by both this block and the mux.
  - typedef enum arb_state_t {IDLE, GRANT}.
- Sub-module rr_priority_picker (combinational):
  - Inputs: req, start index, exclude-enable, exclude index.
  - Outputs: found, winner index.
  - Implementation: rotate, find-first, un-rotate.

Test Plan (M=4, MAX_HOLD=4 unless noted):
- Reset then idle: rst pulse with req=0000 -> grant=0000, select=0, enable=0 for 5 cycles.
- Single request: req=0100 from cycle 0 -> grant=0100, select=2, enable=1 from the next edge. Drop req -> enable=0 one edge later.
- Simultaneous requests and fairness: req=1111 held, each owner drops after 2 cycles and re-raises -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Preemption: req=0011 held constantly -> ch0 granted 4 cycles, preempted pulses, ch1 granted 4 cycles, then ch0. Alone (req=0001) -> grant held indefinitely, preempted stays 0.
- MAX_HOLD=0: req=0011 held 50 cycles -> ch0 keeps grant throughout.
- Async reset mid-grant: rst asserted between edges while grant=1000 -> outputs 0 immediately. After release with req=1001 -> ch0 is granted first.
